// File: rtl/riscv_md_seq_if.sv
// Signal bundle between the control unit / function units and the M-extension sequencer.
// The sequencer connects through the slave modport and the control side through master.
interface riscv_md_seq_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        mul_rst;
    logic        div_rst;
    logic        divu_rst;
    logic        mul_finish;
    logic        div_finish;
    logic        divu_finish;
    logic [63:0] mul_prod;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic [31:0] divu_quot;
    logic [31:0] divu_rem;

    modport master (
        output start, funct3, rs1_val, rs2_val,
        output mul_finish, div_finish, divu_finish,
        output mul_prod, div_quot, div_rem, divu_quot, divu_rem,
        input  busy, done, result, err, unit_a, unit_b,
        input  mul_rst, div_rst, divu_rst
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val,
        input  mul_finish, div_finish, divu_finish,
        input  mul_prod, div_quot, div_rem, divu_quot, divu_rem,
        output busy, done, result, err, unit_a, unit_b,
        output mul_rst, div_rst, divu_rst
    );
endinterface

// File: rtl/riscv_md_seq.sv
// RISC-V M-extension sequencer: latches an op, launches the multiplier or a divider,
// waits (with timeout) for completion and applies sign fix-up or the special-case result.
module riscv_md_seq #(
    parameter int TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst,
    riscv_md_seq_if.slave md
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] LAUNCH = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] FIXUP  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [2:0] state;
    logic [2:0] op;
    logic       neg;
    logic       bypass;
    logic [7:0] cnt;

    logic signed [31:0] rs1_s;
    logic signed [31:0] rs2_s;
    logic [31:0]        abs_rs1;
    logic [31:0]        abs_rs2;
    logic               take_bypass;
    logic               sel_finish;

    // Division special cases never reach a divider: result is known up front.
    function automatic logic [31:0] bypass_value(input logic [2:0] f,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        if (b == 32'h0)
            return f[1] ? a : 32'hFFFF_FFFF;
        return f[1] ? 32'h0 : 32'h8000_0000;
    endfunction

    function automatic logic [31:0] fixup_value(input logic [2:0]  f,
                                                input logic        n,
                                                input logic [63:0] prod,
                                                input logic [31:0] dq,
                                                input logic [31:0] dr,
                                                input logic [31:0] uq,
                                                input logic [31:0] ur);
        logic signed [63:0] p;
        p = n ? -$signed(prod) : $signed(prod);
        case (f)
            3'd0:    return p[31:0];
            3'd1,
            3'd2,
            3'd3:    return p[63:32];
            3'd4:    return dq;
            3'd6:    return dr;
            3'd5:    return uq;
            default: return ur;
        endcase
    endfunction

    assign rs1_s   = $signed(md.rs1_val);
    assign rs2_s   = $signed(md.rs2_val);
    assign abs_rs1 = (rs1_s < 0) ? 32'(-rs1_s) : md.rs1_val;
    assign abs_rs2 = (rs2_s < 0) ? 32'(-rs2_s) : md.rs2_val;

    assign take_bypass = md.funct3[2] &&
                         (md.rs2_val == 32'h0 ||
                          (!md.funct3[0] && md.rs1_val == 32'h8000_0000 &&
                           md.rs2_val == 32'hFFFF_FFFF));

    assign sel_finish = op[2] ? (op[0] ? md.divu_finish : md.div_finish) : md.mul_finish;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op          <= 3'd0;
            neg         <= 1'b0;
            bypass      <= 1'b0;
            cnt         <= 8'd0;
            md.busy     <= 1'b0;
            md.done     <= 1'b0;
            md.err      <= 1'b0;
            md.result   <= 32'h0;
            md.unit_a   <= 32'h0;
            md.unit_b   <= 32'h0;
            md.mul_rst  <= 1'b0;
            md.div_rst  <= 1'b0;
            md.divu_rst <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (md.start) begin
                        op      <= md.funct3;
                        bypass  <= take_bypass;
                        md.busy <= 1'b1;
                        md.unit_a <= (md.funct3 <= 3'd2) ? abs_rs1 : md.rs1_val;
                        md.unit_b <= (md.funct3 <= 3'd1) ? abs_rs2 : md.rs2_val;
                        case (md.funct3)
                            3'd0, 3'd1: neg <= md.rs1_val[31] ^ md.rs2_val[31];
                            3'd2:       neg <= md.rs1_val[31];
                            default:    neg <= 1'b0;
                        endcase
                        // Unit reset is raised on entry to SETUP so it is low again in LAUNCH.
                        md.mul_rst  <= !md.funct3[2];
                        md.div_rst  <= !take_bypass && md.funct3[2] && !md.funct3[0];
                        md.divu_rst <= !take_bypass && md.funct3[2] && md.funct3[0];
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    md.mul_rst  <= 1'b0;
                    md.div_rst  <= 1'b0;
                    md.divu_rst <= 1'b0;
                    if (bypass) begin
                        md.result <= bypass_value(op, md.unit_a, md.unit_b);
                        md.err    <= 1'b0;
                        md.done   <= 1'b1;
                        md.busy   <= 1'b0;
                        state     <= DONE;
                    end else begin
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Level-sampled, so a finish that rose during LAUNCH is still seen here.
                    if (sel_finish) begin
                        state <= FIXUP;
                    end else if (cnt == TO_LAST) begin
                        md.result <= 32'h0;
                        md.err    <= 1'b1;
                        md.done   <= 1'b1;
                        md.busy   <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                FIXUP: begin
                    md.result <= fixup_value(op, neg, md.mul_prod, md.div_quot, md.div_rem,
                                             md.divu_quot, md.divu_rem);
                    md.err    <= 1'b0;
                    md.done   <= 1'b1;
                    md.busy   <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    md.done <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_md_seq.sv
// Randomized and directed bench for riscv_md_seq with behavioural function-unit models
// and an arithmetic reference for every M-extension result.
module tb_riscv_md_seq;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    riscv_md_seq_if mif ();

    riscv_md_seq #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .md  (mif)
    );

    always #5 clk = ~clk;

    // Reference arithmetic straight from the ISA definition, using 64-bit integers.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f)
            3'd0, 3'd1: p = sa * sb;
            3'd2:       p = sa * ub;
            3'd3:       p = ua * ub;
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
        return (f == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return ($signed(v) < 0) ? 32'h0 - v : v;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Function-unit models: each finishes lat cycles after its reset pulse and holds finish.
    int   lat = 0;
    logic fin_kill = 1'b0;
    logic other_hi = 1'b0;
    logic [2:0] armed;
    int   ucnt [3];
    logic [2:0] urst;
    logic [2:0] fin_raw;

    assign urst = {mif.divu_rst, mif.div_rst, mif.mul_rst};

    always @(posedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (rst) begin
                armed[u] <= 1'b0;
                ucnt[u]  <= 0;
            end else if (urst[u]) begin
                armed[u] <= 1'b1;
                ucnt[u]  <= lat;
            end else if (armed[u] && ucnt[u] != 0) begin
                ucnt[u] <= ucnt[u] - 1;
            end
        end
    end

    always_comb begin
        fin_raw = 3'b000;
        for (int u = 0; u < 3; u++)
            fin_raw[u] = armed[u] && (ucnt[u] == 0) && !fin_kill;
    end

    assign mif.mul_finish  = fin_raw[0] | other_hi;
    assign mif.div_finish  = fin_raw[1] | other_hi;
    assign mif.divu_finish = fin_raw[2];
    assign mif.mul_prod    = {32'h0, mif.unit_a} * {32'h0, mif.unit_b};
    assign mif.div_quot    = ref_res(3'd4, mif.unit_a, mif.unit_b);
    assign mif.div_rem     = ref_res(3'd6, mif.unit_a, mif.unit_b);
    assign mif.divu_quot   = ref_res(3'd5, mif.unit_a, mif.unit_b);
    assign mif.divu_rem    = ref_res(3'd7, mif.unit_a, mif.unit_b);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int l, input bit kill, input bit inject);
        int k;
        int rc [3];
        bit byp;
        int exp_lat;
        logic [31:0] exp_res;
        byp = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp_lat = byp ? 2 : (kill ? TO + 3 : ((l + 4 > 5) ? l + 4 : 5));
        exp_res = (kill && !byp) ? 32'h0 : ref_res(f, a, b);
        lat = l;
        fin_kill = kill;
        other_hi = kill;
        @(negedge clk);
        mif.start = 1'b1;
        mif.funct3 = f;
        mif.rs1_val = a;
        mif.rs2_val = b;
        @(negedge clk);
        mif.start = 1'b0;
        mif.rs1_val = $urandom;
        mif.rs2_val = $urandom;
        k = 1;
        rc[0] = int'(mif.mul_rst);
        rc[1] = int'(mif.div_rst);
        rc[2] = int'(mif.divu_rst);
        chk("busy_setup", 64'(mif.busy), 64'd1);
        chk("unit_a", 64'(mif.unit_a), 64'((f <= 3'd2) ? abs32(a) : a));
        chk("unit_b", 64'(mif.unit_b), 64'((f <= 3'd1) ? abs32(b) : b));
        while (!mif.done && k < TO + 20) begin
            if (inject && k == 2) begin
                mif.start = 1'b1;
                mif.funct3 = 3'($urandom);
            end else begin
                mif.start = 1'b0;
            end
            @(negedge clk);
            k++;
            rc[0] += int'(mif.mul_rst);
            rc[1] += int'(mif.div_rst);
            rc[2] += int'(mif.divu_rst);
        end
        mif.start = 1'b0;
        chk("done_seen", 64'(mif.done), 64'd1);
        chk("latency", 64'(k), 64'(exp_lat));
        chk("result", 64'(mif.result), 64'(exp_res));
        chk("err", 64'(mif.err), 64'(kill && !byp));
        chk("busy_done", 64'(mif.busy), 64'd0);
        chk("mul_rst_cnt", 64'(rc[0]), 64'(!byp && !f[2]));
        chk("div_rst_cnt", 64'(rc[1]), 64'(!byp && f[2] && !f[0]));
        chk("divu_rst_cnt", 64'(rc[2]), 64'(!byp && f[2] && f[0]));
        // A start offered while DONE is showing must be dropped.
        mif.start = 1'b1;
        mif.funct3 = 3'($urandom);
        @(negedge clk);
        mif.start = 1'b0;
        chk("done_pulse", 64'(mif.done), 64'd0);
        chk("busy_after", 64'(mif.busy), 64'd0);
        chk("result_hold", 64'(mif.result), 64'(exp_res));
        fin_kill = 1'b0;
        other_hi = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 64'(mif.busy), 64'd0);
        chk({tag, "_done"}, 64'(mif.done), 64'd0);
        chk({tag, "_err"}, 64'(mif.err), 64'd0);
        chk({tag, "_result"}, 64'(mif.result), 64'd0);
        chk({tag, "_ua"}, 64'(mif.unit_a), 64'd0);
        chk({tag, "_ub"}, 64'(mif.unit_b), 64'd0);
        chk({tag, "_rsts"}, 64'(urst), 64'd0);
    endtask

    initial begin
        int seen;
        mif.start = 1'b0;
        mif.funct3 = 3'd0;
        mif.rs1_val = 32'h0;
        mif.rs2_val = 32'h0;
        rst = 1'b1;
        // Start offered during reset must not be taken.
        mif.start = 1'b1;
        repeat (3) @(negedge clk);
        mif.start = 1'b0;
        rst = 1'b0;
        chk_reset_state("reset");

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 3, 1'b0, 1'b0);
        run_op(3'd7, 32'd7, 32'd0, 3, 1'b0, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 1'b0, 1'b0);
        run_op(3'd0, 32'd3, 32'd5, 0, 1'b0, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 4, 1'b1, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 4, 1'b0, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1, 1'b0, 1'b1);

        // Abort in WAIT: nothing completes, state returns to reset values.
        lat = 0;
        fin_kill = 1'b1;
        @(negedge clk);
        mif.start = 1'b1;
        mif.funct3 = 3'd5;
        mif.rs1_val = 32'd50;
        mif.rs2_val = 32'd3;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("midrst");
        seen = 0;
        fin_kill = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen += int'(mif.done);
        end
        chk("midrst_no_done", 64'(seen), 64'd0);
        run_op(3'd5, 32'd50, 32'd3, 2, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++)
            run_op(3'($urandom), pick(), pick(), $urandom_range(0, 10), 1'b0,
                   1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
